riscv_mc_controller: RTL



---
 rtl/riscv_mc_controller.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/riscv_mc_controller.sv
// Main control FSM for the multicycle RV32I core.
// Optional MEM_WAIT_EN: FETCH/MEMREAD/MEMWRITE stall until mem_ready.
module riscv_mc_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [3:0] nzcv,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    state_t st, st_n, dec;
    logic   mem_go;
    logic   taken;

`ifdef MEM_WAIT_EN
    assign mem_go = mem_ready;
`else
    logic unused_mem_ready;
    assign mem_go           = 1'b1;
    assign unused_mem_ready = mem_ready;
`endif

    assign state = st;

    always_ff @(posedge clk) begin
        if (rst) st <= S_FETCH;
        else     st <= st_n;
    end

    always_comb begin
        st_n = st;
        unique case (st)
            S_FETCH:    st_n = mem_go ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: st_n = S_MEMADR;
                    OP_R:              st_n = S_EXECR;
                    OP_I:              st_n = S_EXECI;
                    OP_BR:             st_n = S_BRANCH;
                    OP_JAL:            st_n = S_JAL;
                    OP_JALR:           st_n = S_JALR;
                    OP_LUI:            st_n = S_LUI;
                    OP_AUIPC:          st_n = S_AUIPC;
                    default:           st_n = S_TRAP;
                endcase
            end
            S_MEMADR:   st_n = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  st_n = mem_go ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    st_n = S_FETCH;
            S_MEMWRITE: st_n = mem_go ? S_FETCH : S_MEMWRITE;
            S_EXECR:    st_n = S_ALUWB;
            S_EXECI:    st_n = S_ALUWB;
            S_ALUWB:    st_n = S_FETCH;
            S_BRANCH:   st_n = S_FETCH;
            S_JAL:      st_n = S_ALUWB;
            S_JALR:     st_n = S_JAL;
            S_LUI:      st_n = S_ALUWB;
            S_AUIPC:    st_n = S_ALUWB;
            S_TRAP:     st_n = S_TRAP;
            default:    st_n = S_FETCH;
        endcase
    end

    // nzcv = {N,Z,C,V}; C=1 means no borrow
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = nzcv[2];
            3'b001:  taken = ~nzcv[2];
            3'b100:  taken = nzcv[3] ^ nzcv[0];
            3'b101:  taken = ~(nzcv[3] ^ nzcv[0]);
            3'b110:  taken = ~nzcv[1];
            3'b111:  taken = nzcv[1];
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        ImmSrc = 3'b000;
        case (opcode)
            OP_STORE:        ImmSrc = 3'b001;
            OP_BR:           ImmSrc = 3'b010;
            OP_JAL:          ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
            default:         ImmSrc = 3'b000;
        endcase
    end

    // Under reset the mux selects follow FETCH but no state is written
    assign dec = rst ? S_FETCH : st;

    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        illegal   = 1'b0;
        unique case (dec)
            S_FETCH: begin
                IRWrite   = mem_go;
                PCWrite   = mem_go;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB:    RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                PCWrite = taken;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            S_JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
            end
            S_AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_TRAP:     illegal = 1'b1;
            default: ;
        endcase
        if (rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

endmodule
